// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature encoder emulator driving A/B from step commands
// Optional contact bounce on each transition when ENC_BOUNCE_EN is defined.
module quad_encoder_gen #(
  parameter int PHASE_CYCLES = 3,
  parameter int CNT_W        = 16,
  parameter int BOUNCE_N     = 2
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset,
  input  logic             step_valid,
  input  logic             step_dir,
  input  logic [7:0]       step_count,
  output logic             step_ready,
  output logic             quad_a,
  output logic             quad_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

`ifdef ENC_BOUNCE_EN
  if (PHASE_CYCLES <= 2 * BOUNCE_N + 1 || BOUNCE_N < 1) begin : g_param_chk
    $error("quad_encoder_gen: bounce needs BOUNCE_N >= 1 and PHASE_CYCLES > 2*BOUNCE_N+1");
  end
`else
  if (PHASE_CYCLES < 1 || BOUNCE_N < 0) begin : g_param_chk
    $error("quad_encoder_gen: PHASE_CYCLES must be >= 1");
  end
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    remaining;
  logic          dir;
  logic [1:0]    ab;        // settled {A,B} state
  logic [1:0]    ab_next;

  // CW flips A when A==B, otherwise B; CCW does the opposite.
  always_comb begin
    ab_next = ab;
    if (dir ^ (ab[1] != ab[0])) ab_next[1] = ~ab[1];
    else                        ab_next[0] = ~ab[0];
  end

`ifdef ENC_BOUNCE_EN
  localparam int BW = $clog2(2 * BOUNCE_N + 1);
  logic [BW-1:0] bounce_cnt;
  logic [1:0]    bounce_sel;
`else
  assign quad_a = ab[1];
  assign quad_b = ab[0];
`endif

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      remaining  <= '0;
      dir        <= 1'b0;
      ab         <= 2'b00;
      position   <= '0;
      step_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef ENC_BOUNCE_EN
      quad_a     <= 1'b0;
      quad_b     <= 1'b0;
      bounce_cnt <= '0;
      bounce_sel <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (step_valid) begin
            dir       <= step_dir;
            remaining <= step_count;
            timer     <= RELOAD;
            if (step_count == 8'd0) begin
              done <= 1'b1;
            end else begin
              state      <= RUN;
              step_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef ENC_BOUNCE_EN
          if (bounce_cnt != '0) begin
            quad_a     <= quad_a ^ bounce_sel[1];
            quad_b     <= quad_b ^ bounce_sel[0];
            bounce_cnt <= bounce_cnt - BW'(1);
          end
`endif
          if (remaining != 8'd0) begin
            if (timer == '0) begin
              ab        <= ab_next;
              position  <= dir ? position + CNT_W'(1) : position - CNT_W'(1);
              remaining <= remaining - 8'd1;
              timer     <= RELOAD;
`ifdef ENC_BOUNCE_EN
              quad_a     <= ab_next[1];
              quad_b     <= ab_next[0];
              bounce_sel <= ab ^ ab_next;
              bounce_cnt <= BW'(2 * BOUNCE_N);
`else
              if (remaining == 8'd1) begin
                state      <= IDLE;
                step_ready <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b1;
              end
`endif
            end else begin
              timer <= timer - TW'(1);
            end
          end
`ifdef ENC_BOUNCE_EN
          // Completion waits for the last bounce to settle.
          else if (bounce_cnt <= BW'(1)) begin
            state      <= IDLE;
            step_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - self-checking bench for quad_encoder_gen
module tb_quad_encoder_gen;

  localparam int P = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         step_valid, step_dir;
  logic [7:0]   step_count;
  logic         step_ready, quad_a, quad_b, busy, done;
  logic [W-1:0] position;

  logic         s_valid, s_dir;
  logic [7:0]   s_count;
  logic         s_ready, s_a, s_b, s_busy, s_done;
  logic [3:0]   s_pos;

  always #10 clk = ~clk;

  quad_encoder_gen #(.PHASE_CYCLES(P), .CNT_W(W)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
    .step_count(step_count), .step_ready(step_ready), .quad_a(quad_a), .quad_b(quad_b),
    .busy(busy), .done(done), .position(position)
  );

  quad_encoder_gen #(.PHASE_CYCLES(1), .CNT_W(4)) dut_small (
    .MAX10_CLK1_50(clk), .reset(reset), .step_valid(s_valid), .step_dir(s_dir),
    .step_count(s_count), .step_ready(s_ready), .quad_a(s_a), .quad_b(s_b),
    .busy(s_busy), .done(s_done), .position(s_pos)
  );

  int checks = 0;
  int fails  = 0;
  int m_idx  = 0;
  int m_pos  = 0;
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    bit         dir;
    int         count;
    int         gap;
    logic [1:0] exp_ab;
    logic [15:0] exp_pos;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input int pos,
                           input bit rdy, input bit bsy, input bit dn);
    logic [W-1:0] ep;
    ep = pos[W-1:0];
    chk({tag, " ab"}, 32'({quad_a, quad_b}), 32'(ab_tab[idx]));
    chk({tag, " position"}, 32'(position), 32'(ep));
    chk({tag, " step_ready"}, 32'(step_ready), 32'(rdy));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
    chk({tag, " done"}, 32'(done), 32'(dn));
  endtask

  // Expected trace: after t cycles, floor(t/P) transitions have happened along the Gray table.
  task automatic run_cmd(input bit d, input int n, input bit noise, input int gap);
    int idx0, pos0, j, total;
    idx0 = m_idx;
    pos0 = m_pos;
    step_valid = 1'b1;
    step_dir   = d;
    step_count = n[7:0];
    tick();
    step_valid = 1'b0;
    step_dir   = 1'($urandom);
    step_count = 8'($urandom);
    if (n == 0) begin
      check_out("zero_count", m_idx, m_pos, 1'b1, 1'b0, 1'b1);
    end else begin
      check_out("accept", m_idx, m_pos, 1'b0, 1'b1, 1'b0);
      total = n * P;
      for (int t = 1; t <= total; t++) begin
        if (noise) begin
          step_valid = 1'($urandom);
          step_dir   = 1'($urandom);
          step_count = 8'($urandom);
        end
        tick();
        j = t / P;
        check_out("run", (((idx0 + (d ? j : -j)) % 4) + 4) % 4, pos0 + (d ? j : -j),
                  t == total, t < total, t == total);
      end
      step_valid = 1'b0;
      m_idx = (((idx0 + (d ? n : -n)) % 4) + 4) % 4;
      m_pos = pos0 + (d ? n : -n);
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      check_out("idle_gap", m_idx, m_pos, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{dir: 1'b1, count: 4, gap: 2, exp_ab: 2'b00, exp_pos: 16'h0004};
    vecs[1] = '{dir: 1'b0, count: 4, gap: 1, exp_ab: 2'b00, exp_pos: 16'h0000};
    vecs[2] = '{dir: 1'b0, count: 2, gap: 1, exp_ab: 2'b11, exp_pos: 16'hFFFE};
    vecs[3] = '{dir: 1'b1, count: 0, gap: 2, exp_ab: 2'b11, exp_pos: 16'hFFFE};
    vecs[4] = '{dir: 1'b1, count: 3, gap: 0, exp_ab: 2'b10, exp_pos: 16'h0001};
    vecs[5] = '{dir: 1'b0, count: 1, gap: 1, exp_ab: 2'b00, exp_pos: 16'h0000};

    reset = 1'b1;
    step_valid = 1'b0; step_dir = 1'b0; step_count = 8'd0;
    s_valid = 1'b0; s_dir = 1'b0; s_count = 8'd0;
    tick();
    tick();
    check_out("in_reset", 0, 0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("reset_idle", 0, 0, 1'b1, 1'b0, 1'b0);
    end

    for (int v = 0; v < 6; v++) begin
      run_cmd(vecs[v].dir, vecs[v].count, 1'b1, vecs[v].gap);
      chk("vec final ab", 32'({quad_a, quad_b}), 32'(vecs[v].exp_ab));
      chk("vec final position", 32'(position), 32'(vecs[v].exp_pos));
    end
    tick();

    // Reset in the middle of a command discards it without a done pulse.
    step_valid = 1'b1; step_dir = 1'b1; step_count = 8'd4;
    tick();
    step_valid = 1'b0;
    tick(); tick(); tick();
    check_out("pre_reset", (m_idx + 1) % 4, m_pos + 1, 1'b0, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_idx = 0;
    m_pos = 0;
    check_out("mid_reset", 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_out("post_reset", 0, 0, 1'b1, 1'b0, 1'b0);
    end

    // Reset beats acceptance on the same edge.
    reset = 1'b1; step_valid = 1'b1; step_dir = 1'b1; step_count = 8'd2;
    tick();
    reset = 1'b0; step_valid = 1'b0;
    check_out("reset_prio", 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out("reset_prio_idle", 0, 0, 1'b1, 1'b0, 1'b0);
    end

    for (int r = 0; r < 15; r++) begin
      run_cmd(1'($urandom % 2), int'($urandom % 9), 1'b1, int'($urandom % 3));
    end
    tick();

    // PHASE_CYCLES=1 with a 4-bit counter: one transition per cycle, wrap at 16.
    s_valid = 1'b1; s_dir = 1'b1; s_count = 8'd17;
    tick();
    s_valid = 1'b0;
    chk("small accept busy", 32'(s_busy), 32'd1);
    for (int t = 1; t <= 17; t++) begin
      tick();
      chk("small position", 32'(s_pos), 32'(t % 16));
      chk("small ab", 32'({s_a, s_b}), 32'(ab_tab[t % 4]));
      chk("small done", 32'(s_done), 32'(t == 17));
      chk("small busy", 32'(s_busy), 32'(t < 17));
    end
    chk("small final position", 32'(s_pos), 32'd1);
    chk("small final ab", 32'({s_a, s_b}), 32'(2'b10));
    tick();
    chk("small done clears", 32'(s_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
